// File: rtl/fx2_stream_wr_pkg.sv
// rtl/fx2_stream_wr_pkg.sv - shared state encoding and FX2 constants (package fx2_stream_pkg)
package fx2_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_GAP    = 2'd2
    } wr_state_t;

    localparam logic [1:0] EP6_ADDR = 2'b10;

    // FLAGS_N bit carrying programmable-almost-full (active low)
    localparam int FLAG_PF = 1;

endpackage

// File: rtl/fx2_stream_wr_if.sv
// rtl/fx2_stream_wr_if.sv - upstream stream and FX2 slave-FIFO bus bundle
interface fx2_stream_wr_if;

    logic [15:0] DATA_IN;
    logic        DATA_VALID;
    logic        DATA_READ;
    logic [2:0]  FLAGS_N;
    logic        FX2RDY;
    logic        SLWR_N;
    logic [15:0] DATA_OUT;
    logic        PKTEND_N;
    logic [1:0]  FIFOADDR;
    logic        SLOE_N;
    logic        SLRD_N;

    // master: the writer stage; slave: stream FIFO plus FX2 side
    modport master (
        input  DATA_IN, DATA_VALID, FLAGS_N, FX2RDY,
        output DATA_READ, SLWR_N, DATA_OUT, PKTEND_N, FIFOADDR, SLOE_N, SLRD_N
    );

    modport slave (
        output DATA_IN, DATA_VALID, FLAGS_N, FX2RDY,
        input  DATA_READ, SLWR_N, DATA_OUT, PKTEND_N, FIFOADDR, SLOE_N, SLRD_N
    );

endinterface

// File: rtl/fx2_stream_wr_idle_timer.sv
// rtl/fx2_stream_wr_idle_timer.sv - saturating idle counter with terminal flag (module fx2_idle_timer)
module fx2_idle_timer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            // timeout disabled: never fires
            logic unused_timer;
            assign unused_timer = clk ^ rst_n ^ clear ^ enable;
            assign terminal     = 1'b0;
        end else begin : g_on
            localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

            logic [W-1:0] cnt;

            // count enabled idle cycles, holding at the terminal value
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (enable && cnt != LAST) begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign terminal = (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/fx2_stream_wr.sv
// rtl/fx2_stream_wr.sv - FX2 EP6 slave-FIFO write stage; WORD_CNT/PKT_CNT gated by FX2_STREAM_CNT_EN
module fx2_stream_wr
    import fx2_stream_pkg::*;
#(
    parameter int         PKT_WORDS      = 256,
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter logic [1:0] EP_ADDR        = EP6_ADDR
) (
    input  logic                 STREAM_CLK,
    input  logic                 STREAM_RST_N,
    input  logic                 ENABLE,
    input  logic                 FLUSH,
    fx2_stream_wr_if.master      bus,
    output logic                 BUSY,
    output logic [31:0]          WORD_CNT,
    output logic [15:0]          PKT_CNT
);

    localparam int PW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam logic [PW-1:0] PKT_LAST = PW'(PKT_WORDS - 1);

    wr_state_t   state;
    logic        ready_q;
    logic        flush_pend;
    logic [PW-1:0] pkt_cnt;
    logic        slwr_n_q;
    logic        pktend_n_q;
    logic [15:0] data_q;

    logic accept;
    logic pkt_nz;
    logic auto_commit;
    logic commit_go;
    logic timeout_hit;

    // an accept always wins over a commit in the same cycle
    assign accept      = (state == ST_IDLE) && bus.DATA_VALID && ready_q;
    assign pkt_nz      = (pkt_cnt != '0);
    assign auto_commit = accept && (pkt_cnt == PKT_LAST);
    assign commit_go   = (state == ST_IDLE) && !accept && (flush_pend || timeout_hit)
                         && pkt_nz && ready_q;

    fx2_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk     (STREAM_CLK),
        .rst_n   (STREAM_RST_N),
        .clear   (accept || commit_go),
        .enable  (ENABLE && pkt_nz),
        .terminal(timeout_hit)
    );

    // write path, packet fill tracking and IDLE/COMMIT/GAP sequencing
    always_ff @(posedge STREAM_CLK or negedge STREAM_RST_N) begin
        if (!STREAM_RST_N) begin
            state      <= ST_IDLE;
            ready_q    <= 1'b0;
            flush_pend <= 1'b0;
            pkt_cnt    <= '0;
            slwr_n_q   <= 1'b1;
            pktend_n_q <= 1'b1;
            data_q     <= '0;
        end else begin
            ready_q    <= ENABLE && bus.FX2RDY && bus.FLAGS_N[FLAG_PF];
            slwr_n_q   <= !accept;
            pktend_n_q <= 1'b1;
            if (accept) begin
                data_q <= bus.DATA_IN;
            end

            // a flush only means something when there is (or is about to be) data
            if (commit_go || auto_commit) begin
                flush_pend <= 1'b0;
            end else if (FLUSH && (pkt_nz || accept)) begin
                flush_pend <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        pkt_cnt <= auto_commit ? '0 : pkt_cnt + 1'b1;
                    end else if (commit_go) begin
                        state      <= ST_COMMIT;
                        pktend_n_q <= 1'b0;
                        pkt_cnt    <= '0;
                    end
                end
                ST_COMMIT: state <= ST_GAP;
                ST_GAP:    state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

`ifdef FX2_STREAM_CNT_EN
    logic [31:0] word_total;
    logic [15:0] pkt_total;

    // running totals of written words and committed packets
    always_ff @(posedge STREAM_CLK or negedge STREAM_RST_N) begin
        if (!STREAM_RST_N) begin
            word_total <= '0;
            pkt_total  <= '0;
        end else begin
            if (accept) begin
                word_total <= word_total + 32'd1;
            end
            if (auto_commit || commit_go) begin
                pkt_total <= pkt_total + 16'd1;
            end
        end
    end

    assign WORD_CNT = word_total;
    assign PKT_CNT  = pkt_total;
`else
    assign WORD_CNT = '0;
    assign PKT_CNT  = '0;
`endif

    logic unused_flags;
    assign unused_flags = bus.FLAGS_N[0] ^ bus.FLAGS_N[2];

    assign bus.DATA_READ = accept;
    assign bus.SLWR_N    = slwr_n_q;
    assign bus.DATA_OUT  = data_q;
    assign bus.PKTEND_N  = pktend_n_q;
    assign bus.FIFOADDR  = EP_ADDR;
    assign bus.SLOE_N    = 1'b1;
    assign bus.SLRD_N    = 1'b1;
    assign BUSY          = pkt_nz;

endmodule

// File: tb/tb_fx2_stream_wr.sv
// tb/tb_fx2_stream_wr.sv - self-checking bench for fx2_stream_wr
module tb_fx2_stream_wr;

    localparam int TO = 64;
    localparam int PW = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] word_cnt;
    logic [15:0] pkt_cnt_o;

    fx2_stream_wr_if bus();

    fx2_stream_wr #(
        .PKT_WORDS(PW),
        .TIMEOUT_CYCLES(TO),
        .EP_ADDR(2'b10)
    ) dut (
        .STREAM_CLK(clk),
        .STREAM_RST_N(rst_n),
        .ENABLE(enable),
        .FLUSH(flush),
        .bus(bus),
        .BUSY(busy),
        .WORD_CNT(word_cnt),
        .PKT_CNT(pkt_cnt_o)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] src[$];
    logic [15:0] sent[$];
    logic [15:0] wr_data[$];
    int          wr_cyc[$];
    int          acc_cyc[$];
    int          pe_cyc[$];
    bit          flag_hi[0:8191];
    bit          src_en = 1'b1;
    int          exp_words = 0;
    int          exp_pkts = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cexp(input int v);
`ifdef FX2_STREAM_CNT_EN
        return 32'(v);
`else
        return 32'(v) & 32'd0;
`endif
    endfunction

    // sample at the falling edge, then drive the next cycle's inputs after the rising edge
    task automatic tick();
        @(negedge clk);
        if (cyc < 8192) flag_hi[cyc] = bus.FLAGS_N[1];
        if (bus.DATA_READ === 1'b1) begin
            acc_cyc.push_back(cyc);
            if (src.size() > 0) void'(src.pop_front());
        end
        if (bus.SLWR_N === 1'b0) begin
            wr_data.push_back(bus.DATA_OUT);
            wr_cyc.push_back(cyc);
        end
        if (bus.PKTEND_N === 1'b0) pe_cyc.push_back(cyc);
        @(posedge clk);
        cyc++;
        #1;
        flush = 1'b0;
        bus.DATA_VALID = src_en && (src.size() > 0);
        bus.DATA_IN    = (src.size() > 0) ? src[0] : 16'h0;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic drain(input string tag, input int limit);
        int k = 0;
        while (src.size() > 0 && k < limit) begin
            tick();
            k++;
        end
        chk(tag, 32'(src.size()), 32'd0);
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            logic [15:0] w;
            w = 16'($urandom_range(1, 65535));
            src.push_back(w);
            sent.push_back(w);
        end
    endtask

    task automatic clear_logs();
        sent.delete();
        wr_data.delete();
        wr_cyc.delete();
        acc_cyc.delete();
        pe_cyc.delete();
    endtask

    function automatic int data_mism();
        int m = 0;
        for (int i = 0; i < sent.size(); i++)
            if (i >= wr_data.size() || wr_data[i] !== sent[i]) m++;
        if (wr_data.size() > sent.size()) m += wr_data.size() - sent.size();
        return m;
    endfunction

    function automatic int pe_at(input int i);
        return (pe_cyc.size() > i) ? pe_cyc[i] : -1;
    endfunction

    function automatic int wr_at(input int i);
        return (wr_cyc.size() > i) ? wr_cyc[i] : -1000;
    endfunction

    function automatic int acc_at(input int i);
        return (acc_cyc.size() > i) ? acc_cyc[i] : -1000;
    endfunction

    initial begin
        int a_cyc;
        int flush_cyc;
        int viol;

        bus.DATA_IN = 16'h0;
        bus.DATA_VALID = 1'b0;
        bus.FLAGS_N = 3'b111;
        bus.FX2RDY = 1'b1;
        enable = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_slwr", 32'(bus.SLWR_N), 32'd1);
        chk("rst_pktend", 32'(bus.PKTEND_N), 32'd1);
        chk("rst_data", 32'(bus.DATA_OUT), 32'd0);
        chk("rst_read", 32'(bus.DATA_READ), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wcnt", word_cnt, 32'd0);
        chk("rst_pcnt", 32'(pkt_cnt_o), 32'd0);
        chk("fifoaddr", 32'(bus.FIFOADDR), 32'd2);
        chk("sloe", 32'(bus.SLOE_N), 32'd1);
        chk("slrd", 32'(bus.SLRD_N), 32'd1);
        rst_n = 1'b1;

        // full packet: FX2 auto-commits, no PKTEND
        clear_logs();
        push_words(PW);
        drain("t1_drain", 600);
        run(80);
        exp_words += PW;
        exp_pkts += 1;
        chk("t1_count", 32'(wr_data.size()), 32'(PW));
        chk("t1_data", 32'(data_mism()), 32'd0);
        chk("t1_b2b", 32'(wr_at(PW - 1) - wr_at(0)), 32'(PW - 1));
        chk("t1_no_pktend", 32'(pe_cyc.size()), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_pcnt", 32'(pkt_cnt_o), cexp(exp_pkts));
        chk("t1_wcnt", word_cnt, cexp(exp_words));

        // short packet closed by idle timeout
        clear_logs();
        push_words(10);
        drain("t2_drain", 100);
        run(2);
        chk("t2_busy_pend", 32'(busy), 32'd1);
        run(100);
        exp_words += 10;
        exp_pkts += 1;
        chk("t2_data", 32'(data_mism()), 32'd0);
        chk("t2_pe_once", 32'(pe_cyc.size()), 32'd1);
        chk("t2_pe_time", 32'(pe_at(0) - wr_at(9)), 32'(TO));
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_pcnt", 32'(pkt_cnt_o), cexp(exp_pkts));
        chk("t2_wcnt", word_cnt, cexp(exp_words));

        // flush with nothing pending, then flush together with the third word
        clear_logs();
        flush = 1'b1;
        tick();
        run(100);
        chk("t3_empty_flush", 32'(pe_cyc.size()), 32'd0);
        push_words(3);
        tick();
        tick();
        tick();
        flush = 1'b1;
        flush_cyc = cyc;
        tick();
        push_words(1);
        run(110);
        exp_words += 4;
        exp_pkts += 2;
        chk("t3_data", 32'(data_mism()), 32'd0);
        chk("t3_flush_with_acc", 32'(acc_at(2)), 32'(flush_cyc));
        chk("t3_pe_count", 32'(pe_cyc.size()), 32'd2);
        chk("t3_pe_after_wr", 32'(pe_at(0) - wr_at(2)), 32'd1);
        chk("t3_gap", 32'(acc_at(3) - pe_at(0)), 32'd2);
        chk("t3_pe2_time", 32'(pe_at(1) - wr_at(3)), 32'(TO));

        // almost-full toggling during a burst of 100
        clear_logs();
        push_words(100);
        begin
            int k = 0;
            while (src.size() > 0 && k < 2000) begin
                tick();
                bus.FLAGS_N = {1'b1, ($urandom_range(0, 3) != 0), 1'b1};
                k++;
            end
        end
        bus.FLAGS_N = 3'b111;
        chk("t4_drain", 32'(src.size()), 32'd0);
        run(100);
        exp_words += 100;
        exp_pkts += 1;
        viol = 0;
        foreach (wr_cyc[i])
            if (wr_cyc[i] >= 2 && wr_cyc[i] < 8192 && !flag_hi[wr_cyc[i] - 2]) viol++;
        chk("t4_data", 32'(data_mism()), 32'd0);
        chk("t4_stall", 32'(viol), 32'd0);
        chk("t4_pe_time", 32'(pe_at(0) - wr_at(99)), 32'(TO));

        // word arriving in the timeout cycle
        clear_logs();
        push_words(1);
        begin
            int k = 0;
            while (acc_cyc.size() == 0 && k < 20) begin
                tick();
                k++;
            end
        end
        a_cyc = (acc_cyc.size() > 0) ? acc_cyc[0] : cyc;
        while (cyc < a_cyc + TO - 1) tick();
        push_words(1);
        run(160);
        exp_words += 2;
        exp_pkts += 1;
        chk("t5_data", 32'(data_mism()), 32'd0);
        chk("t5_acc_time", 32'(acc_at(1) - a_cyc), 32'(TO));
        chk("t5_pe_once", 32'(pe_cyc.size()), 32'd1);
        chk("t5_pe_time", 32'(pe_at(0) - wr_at(1)), 32'(TO));
        chk("t5_pcnt", 32'(pkt_cnt_o), cexp(exp_pkts));
        chk("t5_wcnt", word_cnt, cexp(exp_words));

        // asynchronous reset while a write strobe is active
        clear_logs();
        push_words(5);
        run(3);
        chk("t6_pre_slwr", 32'(bus.SLWR_N), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_slwr", 32'(bus.SLWR_N), 32'd1);
        chk("t6_data", 32'(bus.DATA_OUT), 32'd0);
        chk("t6_pktend", 32'(bus.PKTEND_N), 32'd1);
        chk("t6_read", 32'(bus.DATA_READ), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_wcnt", word_cnt, 32'd0);
        chk("t6_pcnt", 32'(pkt_cnt_o), 32'd0);
        src.delete();
        bus.DATA_VALID = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pe_cyc.delete();
        run(100);
        chk("t6_no_commit", 32'(pe_cyc.size()), 32'd0);
        chk("t6_busy_after", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
